sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//   Shares the single-port 24x4096 survivor SRAM between two requesters:
//   - write requester: ACS survivor writer.
//   - read requester: traceback unit.
//   Write has priority, with a bounded starvation limit for reads.
//   Drives the SRAM's wr_en/rd_en/addr/wdata and returns registered read data with a valid strobe.
// PARAMETERS
//   ADDR_W        12  SRAM address width
//   DATA_W        24  SRAM word width
//   WR_BURST_MAX   4  max consecutive write grants while a read waits (1..2^BURST_W-1)
//   BURST_W        3  width of burst counter
//   CNT_W         16  width of statistics counters
// PORTS
//   clk_i          in   1       single clock; all state on rising edge
//   rst_i          in   1       synchronous reset, active-high
//   hold_i         in   1       1: no grants issued (SRAM idle)
//   wr_req_i       in   1       write request
//   wr_addr_i      in   ADDR_W  write address
//   wr_data_i      in   DATA_W  write data
//   wr_gnt_o       out  1       write accepted this cycle
//   rd_req_i       in   1       read request; held with rd_addr_i until rd_gnt_o
//   rd_addr_i      in   ADDR_W  read address
//   rd_gnt_o       out  1       read accepted this cycle
//   rd_rvalid_o    out  1       rd_rdata_o valid (1 cycle after rd_gnt_o)
//   rd_rdata_o     out  DATA_W  read data (= sram_rdata_i)
//   sram_wr_en_o   out  1       to SRAM wr_en_i
//   sram_rd_en_o   out  1       to SRAM rd_en_i
//   sram_addr_o    out  ADDR_W  to SRAM addr_i
//   sram_wdata_o   out  DATA_W  to SRAM wdata_i
//   sram_rdata_i   in   DATA_W  from SRAM rdata_o (registered in SRAM, 1-cycle latency)
//   stat_clr_i     in   1       clear statistics counters
//   stat_wr_o      out  CNT_W   write grants
//   stat_rd_o      out  CNT_W   read grants
//   stat_stall_o   out  CNT_W   cycles with rd_req_i=1 and rd_gnt_o=0
// BEHAVIOUR
//   - Grants are combinational from the requests plus registered state.
//     At most one grant per cycle. No grant while rst_i or hold_i is 1.
//   - Priority FSM, registered burst_cnt (0..WR_BURST_MAX):
//     * WR_PRI (burst_cnt<WR_BURST_MAX): wr_req -> wr_gnt; else rd_req -> rd_gnt.
//     * RD_PRI (burst_cnt==WR_BURST_MAX): rd_req -> rd_gnt; else wr_req -> wr_gnt.
//   - burst_cnt update:
//     * +1 on wr_gnt while rd_req_i=1.
//     * Cleared on rd_gnt, or when rd_req_i=0.
//     * Held when no grant is issued (hold_i=1).
//   - SRAM drive:
//     * sram_wr_en_o=wr_gnt_o; sram_rd_en_o=rd_gnt_o.
//     * sram_addr_o = wr_addr_i if wr_gnt, else rd_addr_i.
//     * sram_wdata_o = wr_data_i.
//   - Read response: rd_rvalid_o is registered rd_gnt_o.
//     rd_rdata_o = sram_rdata_i, meaningful only while rd_rvalid_o=1.
//   - Back-to-back reads sustain 1 word/cycle.
//   - A read granted the cycle after a write to the same address returns the new data.
//   - Reset values:
//     * rd_rvalid_o=0, burst_cnt=0, all grants and SRAM enables 0.
//     * stat_* are 0 when STATS is compiled in.
//   - Reset mid-operation: a grant pending in the reset cycle is not issued.
//     An in-flight rd_rvalid_o is dropped (0 the next cycle).
//     SRAM contents are not touched.
//   - hold_i=1 while rd_rvalid_o is pending: the response is still delivered.
// CONFIGURATION
//   SRAM_ARB_STATS_EN defined:
//     * stat_wr_o, stat_rd_o, stat_stall_o count their events.
//     * Saturate at all-ones.
//     * Synchronous clear on stat_clr_i; clear wins over increment in the same cycle.
//   Not defined: stat_* tied to 0, stat_clr_i ignored, no counter flops.
// TESTING
//   1 Write-only: wr_req=1 for 8 cycles, addr 0..7, data 0xA00000+n
//     -> wr_gnt=1 every cycle.
//     Later reads of 0..7 return 0xA00000..0xA00007, rvalid exactly 1 cycle after each rd_gnt.
//   2 Contention: wr_req and rd_req held high, WR_BURST_MAX=4
//     -> grant pattern W,W,W,W,R repeating; stat_stall_o increments 4 per period.
//   3 RAW: write 0x123456 to 0xFFF, then read 0xFFF next cycle
//     -> rd_rdata_o=0x123456 with rvalid.
//     Read of 0x000 after 0xFFF wraps correctly.
//   4 hold_i=1 for 3 cycles with both requests high
//     -> no grants, no SRAM enables, burst_cnt unchanged.
//     The pending rvalid from the prior read still asserts.
//   5 rst_i asserted the cycle after a rd_gnt
//     -> rd_rvalid_o=0 next cycle, grants 0 during reset.
//     After release, the first contended cycle grants write.
//   6 STATS: counters preset near 0xFFFF, keep granting
//     -> saturate at 0xFFFF; stat_clr_i with a grant in the same cycle -> 0.
//     Without the macro, all stat_* are 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_port_arbiter.
// slave = arbiter view, master = requester/SRAM environment view.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 24
);
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_gnt_o;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_gnt_o;
  logic              rd_rvalid_o;
  logic [DATA_W-1:0] rd_rdata_o;
  logic              sram_wr_en_o;
  logic              sram_rd_en_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_wdata_o;
  logic [DATA_W-1:0] sram_rdata_i;

  modport slave (
    input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, sram_rdata_i,
    output wr_gnt_o, rd_gnt_o, rd_rvalid_o, rd_rdata_o,
           sram_wr_en_o, sram_rd_en_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, sram_rdata_i,
    input  wr_gnt_o, rd_gnt_o, rd_rvalid_o, rd_rdata_o,
           sram_wr_en_o, sram_rd_en_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Write-priority arbiter for the single-port survivor SRAM with a bounded read starvation limit.
// Optional statistics counters are compiled in with `define SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned WR_BURST_MAX = 4,
  parameter int unsigned BURST_W      = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  sram_port_arbiter_if.slave bus,
  input  logic             stat_clr_i,
  output logic [CNT_W-1:0] stat_wr_o,
  output logic [CNT_W-1:0] stat_rd_o,
  output logic [CNT_W-1:0] stat_stall_o
);

  typedef enum logic {WR_PRI, RD_PRI} pri_e;

  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rd_rvalid_q, rd_rvalid_d;
  pri_e               pri;
  logic               wr_gnt, rd_gnt;

  // Priority flips to the reader once WR_BURST_MAX writes have jumped a waiting read
  always_comb begin
    wr_gnt      = 1'b0;
    rd_gnt      = 1'b0;
    burst_cnt_d = burst_cnt_q;
    pri         = (burst_cnt_q == BURST_W'(WR_BURST_MAX)) ? RD_PRI : WR_PRI;
    if (!rst_i && !hold_i) begin
      if (pri == RD_PRI) begin
        rd_gnt = bus.rd_req_i;
        wr_gnt = bus.wr_req_i & ~bus.rd_req_i;
      end else begin
        wr_gnt = bus.wr_req_i;
        rd_gnt = bus.rd_req_i & ~bus.wr_req_i;
      end
      if (rd_gnt || !bus.rd_req_i) begin
        burst_cnt_d = '0;
      end else if (wr_gnt) begin
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end
    end
    rd_rvalid_d = rd_gnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      burst_cnt_q <= '0;
      rd_rvalid_q <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rd_rvalid_q <= rd_rvalid_d;
    end
  end

  assign bus.wr_gnt_o     = wr_gnt;
  assign bus.rd_gnt_o     = rd_gnt;
  assign bus.sram_wr_en_o = wr_gnt;
  assign bus.sram_rd_en_o = rd_gnt;
  assign bus.sram_addr_o  = wr_gnt ? bus.wr_addr_i : bus.rd_addr_i;
  assign bus.sram_wdata_o = bus.wr_data_i;
  assign bus.rd_rvalid_o  = rd_rvalid_q;
  assign bus.rd_rdata_o   = bus.sram_rdata_i;

`ifdef SRAM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stat_wr_q, stat_wr_d;
  logic [CNT_W-1:0] stat_rd_q, stat_rd_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  // Saturating event counters; clear beats a same-cycle increment
  always_comb begin
    stat_wr_d    = stat_wr_q;
    stat_rd_d    = stat_rd_q;
    stat_stall_d = stat_stall_q;
    if (stat_clr_i) begin
      stat_wr_d    = '0;
      stat_rd_d    = '0;
      stat_stall_d = '0;
    end else begin
      if (wr_gnt && stat_wr_q != CNT_MAX) stat_wr_d = stat_wr_q + CNT_W'(1);
      if (rd_gnt && stat_rd_q != CNT_MAX) stat_rd_d = stat_rd_q + CNT_W'(1);
      if (bus.rd_req_i && !rd_gnt && stat_stall_q != CNT_MAX)
        stat_stall_d = stat_stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_wr_q    <= stat_wr_d;
      stat_rd_q    <= stat_rd_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_wr_o    = stat_wr_q;
  assign stat_rd_o    = stat_rd_q;
  assign stat_stall_o = stat_stall_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_wr_o       = '0;
  assign stat_rd_o       = '0;
  assign stat_stall_o    = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model of grants, memory and statistics.
module tb_sram_port_arbiter;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 24;
  localparam int unsigned BMAX = 4;
  localparam int unsigned BW   = 3;
  localparam int unsigned CW   = 16;
  localparam int          SMAX = 65535;

  logic          clk = 1'b0;
  logic          rst, hold, clr;
  logic [CW-1:0] s_wr, s_rd, s_stall;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WR_BURST_MAX(BMAX), .BURST_W(BW), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .bus(bus),
    .stat_clr_i(clr), .stat_wr_o(s_wr), .stat_rd_o(s_rd), .stat_stall_o(s_stall)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered read data
  logic [DW-1:0] sram [4096];
  always @(posedge clk) begin
    if (bus.sram_wr_en_o) sram[bus.sram_addr_o] <= bus.sram_wdata_o;
    if (bus.sram_rd_en_o) bus.sram_rdata_i <= sram[bus.sram_addr_o];
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: writes granted to a read since it started waiting, memory image, pending response
  int            m_wait = 0;
  bit            m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [4096];
  int            m_swr = 0, m_srd = 0, m_sstall = 0;

  always @(negedge clk) begin
    bit            ew, er;
    logic [AW-1:0] ea;
    if (chk_en) begin
      ew = 1'b0;
      er = 1'b0;
      if (!rst && !hold) begin
        if (bus.rd_req_i && (m_wait >= BMAX || !bus.wr_req_i)) er = 1'b1;
        else if (bus.wr_req_i) ew = 1'b1;
      end
      ea = ew ? bus.wr_addr_i : bus.rd_addr_i;
      chk("wr_gnt", 32'(bus.wr_gnt_o), 32'(ew));
      chk("rd_gnt", 32'(bus.rd_gnt_o), 32'(er));
      chk("sram_wr_en", 32'(bus.sram_wr_en_o), 32'(ew));
      chk("sram_rd_en", 32'(bus.sram_rd_en_o), 32'(er));
      chk("sram_addr", 32'(bus.sram_addr_o), 32'(ea));
      chk("sram_wdata", 32'(bus.sram_wdata_o), 32'(bus.wr_data_i));
      chk("rd_rvalid", 32'(bus.rd_rvalid_o), 32'(m_rvalid));
      if (m_rvalid) chk("rd_rdata", 32'(bus.rd_rdata_o), 32'(m_rdata));
      chk("stat_wr", 32'(s_wr), 32'(m_swr));
      chk("stat_rd", 32'(s_rd), 32'(m_srd));
      chk("stat_stall", 32'(s_stall), 32'(m_sstall));

      if (rst) m_wait = 0;
      else if (!hold) begin
        if (er || !bus.rd_req_i) m_wait = 0;
        else if (ew) m_wait++;
      end
      m_rvalid = er;
      if (er) m_rdata = m_mem[bus.rd_addr_i];
      if (ew) m_mem[bus.wr_addr_i] = bus.wr_data_i;
`ifdef SRAM_ARB_STATS_EN
      if (rst || clr) begin
        m_swr = 0; m_srd = 0; m_sstall = 0;
      end else begin
        if (ew && m_swr < SMAX) m_swr++;
        if (er && m_srd < SMAX) m_srd++;
        if (bus.rd_req_i && !er && m_sstall < SMAX) m_sstall++;
      end
`endif
    end
  end

  task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rd, input logic [AW-1:0] ra,
                       input logic hd = 1'b0, input logic rs = 1'b0, input logic cl = 1'b0);
    @(posedge clk); #1;
    bus.wr_req_i  = wr;
    bus.wr_addr_i = wa;
    bus.wr_data_i = wd;
    bus.rd_req_i  = rd;
    bus.rd_addr_i = ra;
    hold = hd;
    rst  = rs;
    clr  = cl;
    @(negedge clk); #1;
  endtask

  initial begin
    int            s0;
    bit            rd_pend;
    logic [AW-1:0] ra;
    for (int i = 0; i < 4096; i++) m_mem[i] = '0;
    rst = 1'b1; hold = 1'b0; clr = 1'b0;
    bus.wr_req_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rd_req_i = 1'b0; bus.rd_addr_i = '0;

    drive(1, 0, 0, 1, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0, 1);
    chk("reset_wr_gnt", 32'(bus.wr_gnt_o), 0);
    chk("reset_rd_gnt", 32'(bus.rd_gnt_o), 0);
    chk("reset_rvalid", 32'(bus.rd_rvalid_o), 0);
    chk("reset_stat_wr", 32'(s_wr), 0);
    chk_en = 1'b1;

    // Write-only burst then back-to-back reads
    for (int n = 0; n < 8; n++) begin
      drive(1, AW'(n), DW'(24'hA00000 + n), 0, 0);
      chk("t1_wr_gnt", 32'(bus.wr_gnt_o), 1);
    end
    for (int n = 0; n < 9; n++) begin
      drive(0, 0, 0, (n < 8), AW'(n));
      if (n < 8) chk("t1_rd_gnt", 32'(bus.rd_gnt_o), 1);
      if (n > 0) begin
        chk("t1_rvalid", 32'(bus.rd_rvalid_o), 1);
        chk("t1_rdata", 32'(bus.rd_rdata_o), 32'h00A00000 + 32'(n - 1));
      end
    end
    drive(0, 0, 0, 0, 0);
    chk("t1_rvalid_end", 32'(bus.rd_rvalid_o), 0);

    // Contention: W,W,W,W,R repeating
    drive(0, 0, 0, 0, 0);
    s0 = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, AW'(8 + i % 8), DW'($urandom), 1, 3);
      if (i == 0) s0 = int'(s_stall);
      chk("t2_wr_gnt", 32'(bus.wr_gnt_o), 32'(i % 5 != 4));
      chk("t2_rd_gnt", 32'(bus.rd_gnt_o), 32'(i % 5 == 4));
`ifdef SRAM_ARB_STATS_EN
      if (i == 5) chk("t2_stall_per_period", 32'(int'(s_stall) - s0), 4);
`endif
    end

    // Read-after-write at the top address, then wrap to 0
    drive(0, 0, 0, 0, 0);
    drive(1, 12'hFFF, 24'h123456, 0, 0);
    chk("t3_wr_gnt", 32'(bus.wr_gnt_o), 1);
    drive(0, 0, 0, 1, 12'hFFF);
    chk("t3_rd_gnt", 32'(bus.rd_gnt_o), 1);
    chk("t3_addr_fff", 32'(bus.sram_addr_o), 32'hFFF);
    drive(0, 0, 0, 1, 12'h000);
    chk("t3_rvalid", 32'(bus.rd_rvalid_o), 1);
    chk("t3_rdata_raw", 32'(bus.rd_rdata_o), 32'h123456);
    chk("t3_addr_000", 32'(bus.sram_addr_o), 0);
    drive(0, 0, 0, 0, 0);
    chk("t3_rdata_wrap", 32'(bus.rd_rdata_o), 32'hA00000);

    // Hold with a response in flight
    drive(0, 0, 0, 1, 1);
    chk("t4_rd_gnt", 32'(bus.rd_gnt_o), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 24'h55, 1, 1, 1);
      chk("t4_hold_wr_en", 32'(bus.sram_wr_en_o), 0);
      chk("t4_hold_rd_en", 32'(bus.sram_rd_en_o), 0);
      if (i == 0) begin
        chk("t4_hold_rvalid", 32'(bus.rd_rvalid_o), 1);
        chk("t4_hold_rdata", 32'(bus.rd_rdata_o), 32'hA00001);
      end
    end
    // Hold preserves a partial write burst: W,W | hold x3 | W,W,R
    drive(0, 0, 0, 0, 0);
    drive(1, 10, 24'h1, 1, 4);
    drive(1, 10, 24'h2, 1, 4);
    for (int i = 0; i < 3; i++) begin
      drive(1, 10, 24'h3, 1, 4, 1);
      chk("t4b_hold_gnt", 32'({bus.wr_gnt_o, bus.rd_gnt_o}), 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 10, 24'h4, 1, 4);
      chk("t4b_rd_gnt", 32'(bus.rd_gnt_o), 32'(i == 2));
    end

    // Reset the cycle after a read grant
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2);
    chk("t5_rd_gnt", 32'(bus.rd_gnt_o), 1);
    drive(1, 11, 24'h77, 1, 2, 0, 1);
    chk("t5_rst_gnt", 32'({bus.wr_gnt_o, bus.rd_gnt_o}), 0);
    chk("t5_rst_en", 32'({bus.sram_wr_en_o, bus.sram_rd_en_o}), 0);
    drive(1, 11, 24'h77, 1, 2);
    chk("t5_rvalid_dropped", 32'(bus.rd_rvalid_o), 0);
    chk("t5_first_wr", 32'(bus.wr_gnt_o), 1);
    chk("t5_first_rd", 32'(bus.rd_gnt_o), 0);

`ifdef SRAM_ARB_STATS_EN
    // Saturation and clear-over-increment
    for (int i = 0; i < 65540; i++) drive(1, AW'(8 + i % 8), DW'(i), 0, 0);
    chk("t6_sat_wr", 32'(s_wr), 32'hFFFF);
    drive(1, 8, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk("t6_clr_wr", 32'(s_wr), 0);
    chk("t6_clr_stall", 32'(s_stall), 0);
`else
    chk("t6_nostat_wr", 32'(s_wr), 0);
    chk("t6_nostat_rd", 32'(s_rd), 0);
    chk("t6_nostat_stall", 32'(s_stall), 0);
`endif

    // Random traffic; a read request stays up with its address until granted
    rd_pend = 1'b0;
    ra = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!rd_pend && $urandom_range(0, 1) == 1) begin
        rd_pend = 1'b1;
        ra = AW'($urandom_range(0, 7));
      end
      drive(($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), DW'($urandom), rd_pend, ra,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
      if (bus.rd_gnt_o) rd_pend = 1'b0;
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
